// File: rtl/prt_dp_pm_rom_ldr.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// prt_dp_pm_rom_ldr
//
// Purpose:
//   Turns a host byte stream (a policy-maker program image) into the word
//   write stream of the program ROM init port. Each image begins with a
//   write-pointer clear pulse. Bytes are packed little-endian into 32-bit
//   words, and each completed word is written with a single-cycle strobe.
//   Busy, done, error and word-count status are reported back to the host.
//
// Parameters:
//   P_ADR         ROM address bits; the ROM holds 2**P_ADR words.
//
// Ports:
//   CLK_IN        clock
//   RST_IN        asynchronous active-high reset
//   HOST_STR_IN   start-of-image pulse (restarts from any state)
//   HOST_DAT_IN   image byte
//   HOST_VLD_IN   byte valid
//   HOST_END_IN   last byte of image, qualified by the byte handshake
//   HOST_RDY_OUT  loader ready for a byte (registered, high only while loading)
//   INIT_STR_OUT  ROM write-pointer clear pulse
//   INIT_DAT_OUT  ROM word
//   INIT_VLD_OUT  ROM word write strobe
//   BUSY_OUT      image load in progress
//   DONE_OUT      load completed
//   ERR_OUT       load error (overflow, or checksum when enabled)
//   WRDS_OUT      words written to ROM since the last clear pulse
//
// Optional feature (macro PRT_DP_PM_ROM_LDR_CKS_EN):
//   The image's last word is a checksum. It is compared against the
//   modulo-2^32 sum of the written words and is never written to the ROM.
// ---------------------------------------------------------------------------
module prt_dp_pm_rom_ldr #(
  parameter int P_ADR = 10
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  input  logic             HOST_STR_IN,
  input  logic [7:0]       HOST_DAT_IN,
  input  logic             HOST_VLD_IN,
  input  logic             HOST_END_IN,
  output logic             HOST_RDY_OUT,
  output logic             INIT_STR_OUT,
  output logic [31:0]      INIT_DAT_OUT,
  output logic             INIT_VLD_OUT,
  output logic             BUSY_OUT,
  output logic             DONE_OUT,
  output logic             ERR_OUT,
  output logic [P_ADR:0]   WRDS_OUT
);

  // ROM capacity in words; WRDS_OUT is one bit wider so that it can hold it
  localparam logic [P_ADR:0] LP_WRDS = {1'b1, {P_ADR{1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STR  = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     r_state;
  logic [1:0]     r_idx;
  logic [31:0]    r_shadow;
  logic [P_ADR:0] r_wrds;
  logic           r_rdy;
  logic           r_init_str;
  logic [31:0]    r_init_dat;
  logic           r_init_vld;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
`ifdef PRT_DP_PM_ROM_LDR_CKS_EN
  logic [31:0]    r_sum;
`endif

  logic           w_accept;
  logic           w_last;
  logic [31:0]    w_word;

  // r_rdy is high only in LOAD, so it also qualifies the state. A start in
  // the same cycle wins, which drops the byte.
  assign w_accept = HOST_VLD_IN & r_rdy & ~HOST_STR_IN;
  assign w_last   = (r_idx == 2'd3) | HOST_END_IN;

  // The word as it looks with the current byte merged in. The shadow is
  // cleared after every emitted word, so a short final word is already
  // zero-padded.
  always_comb begin
    w_word = r_shadow;
    w_word[8*r_idx +: 8] = HOST_DAT_IN;
  end

  // Loader state machine. All host and ROM outputs are registered. The clear
  // pulse and the write strobe default low, so each lasts exactly one cycle.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_shadow   <= 32'd0;
      r_wrds     <= '0;
      r_rdy      <= 1'b0;
      r_init_str <= 1'b0;
      r_init_dat <= 32'd0;
      r_init_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef PRT_DP_PM_ROM_LDR_CKS_EN
      r_sum      <= 32'd0;
`endif
    end else begin
      r_init_str <= 1'b0;
      r_init_vld <= 1'b0;
      if (HOST_STR_IN) begin
        // Start from any state. Any partial word is discarded.
        r_state    <= S_STR;
        r_init_str <= 1'b1;
        r_idx      <= 2'd0;
        r_shadow   <= 32'd0;
        r_wrds     <= '0;
        r_rdy      <= 1'b0;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
`ifdef PRT_DP_PM_ROM_LDR_CKS_EN
        r_sum      <= 32'd0;
`endif
      end else begin
        case (r_state)
          S_STR: begin
            r_state <= S_LOAD;
            r_rdy   <= 1'b1;
          end
          S_LOAD: begin
            if (w_accept) begin
              if (r_wrds == LP_WRDS) begin
                // ROM already full: drop the byte and stop with an error
                r_err   <= 1'b1;
                r_state <= S_DONE;
                r_rdy   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (w_last) begin
                r_idx    <= 2'd0;
                r_shadow <= 32'd0;
`ifdef PRT_DP_PM_ROM_LDR_CKS_EN
                if (HOST_END_IN) begin
                  // The END word is the checksum. It is checked, not written.
                  r_err   <= (r_idx != 2'd3) | (r_sum != w_word);
                  r_state <= S_DONE;
                  r_rdy   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_init_dat <= w_word;
                  r_init_vld <= 1'b1;
                  r_wrds     <= r_wrds + 1'b1;
                  r_sum      <= r_sum + w_word;
                end
`else
                r_init_dat <= w_word;
                r_init_vld <= 1'b1;
                r_wrds     <= r_wrds + 1'b1;
                if (HOST_END_IN) begin
                  r_state <= S_DONE;
                  r_rdy   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
`endif
              end else begin
                r_shadow <= w_word;
                r_idx    <= r_idx + 2'd1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign HOST_RDY_OUT = r_rdy;
  assign INIT_STR_OUT = r_init_str;
  assign INIT_DAT_OUT = r_init_dat;
  assign INIT_VLD_OUT = r_init_vld;
  assign BUSY_OUT     = r_busy;
  assign DONE_OUT     = r_done;
  assign ERR_OUT      = r_err;
  assign WRDS_OUT     = r_wrds;

endmodule

// File: tb/tb_prt_dp_pm_rom_ldr.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_prt_dp_pm_rom_ldr
//
// Scoreboard bench for the ROM loader. It uses a small ROM (P_ADR=2, four
// words) so that overflow is reached often. Each image is turned into its
// expected word list from byte positions and simple arithmetic, and that
// list is queued. A monitor pops an entry on every ROM write strobe.
// ---------------------------------------------------------------------------
module tb_prt_dp_pm_rom_ldr;

  localparam int P_ADR = 2;
  localparam int CAP   = 2**P_ADR;

  logic           CLK_IN      = 1'b0;
  logic           RST_IN      = 1'b1;
  logic           HOST_STR_IN = 1'b0;
  logic [7:0]     HOST_DAT_IN = 8'd0;
  logic           HOST_VLD_IN = 1'b0;
  logic           HOST_END_IN = 1'b0;
  logic           HOST_RDY_OUT;
  logic           INIT_STR_OUT;
  logic [31:0]    INIT_DAT_OUT;
  logic           INIT_VLD_OUT;
  logic           BUSY_OUT;
  logic           DONE_OUT;
  logic           ERR_OUT;
  logic [P_ADR:0] WRDS_OUT;

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] wrds;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monE;
  logic [7:0] imgQ[$];
  int         checks  = 0;
  int         errors  = 0;
  int         strExp  = 0;
  int         strSeen = 0;

  prt_dp_pm_rom_ldr #(.P_ADR(P_ADR)) dut (
    .CLK_IN       (CLK_IN),
    .RST_IN       (RST_IN),
    .HOST_STR_IN  (HOST_STR_IN),
    .HOST_DAT_IN  (HOST_DAT_IN),
    .HOST_VLD_IN  (HOST_VLD_IN),
    .HOST_END_IN  (HOST_END_IN),
    .HOST_RDY_OUT (HOST_RDY_OUT),
    .INIT_STR_OUT (INIT_STR_OUT),
    .INIT_DAT_OUT (INIT_DAT_OUT),
    .INIT_VLD_OUT (INIT_VLD_OUT),
    .BUSY_OUT     (BUSY_OUT),
    .DONE_OUT     (DONE_OUT),
    .ERR_OUT      (ERR_OUT),
    .WRDS_OUT     (WRDS_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: samples on the falling edge, pops the expected word on every
  // write strobe, and counts clear-pulse cycles.
  always @(negedge CLK_IN) begin
    if (!RST_IN) begin
      if (INIT_STR_OUT) strSeen++;
      if (INIT_VLD_OUT) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word actual=%08h required=none", INIT_DAT_OUT);
        end else begin
          monE = expQ.pop_front();
          chk("word_data", 64'(INIT_DAT_OUT), 64'(monE.dat));
          chk("word_count", 64'(WRDS_OUT), 64'(monE.wrds));
        end
      end
    end
  end

  // One-cycle start pulse, then check the loader's STR-state outputs
  task automatic pulseStart();
    HOST_STR_IN = 1'b1;
    @(negedge CLK_IN);
    HOST_STR_IN = 1'b0;
    strExp++;
    chk("str_pulse", 64'(INIT_STR_OUT), 64'd1);
    chk("str_wrds_clear", 64'(WRDS_OUT), 64'd0);
    chk("str_rdy_low", 64'(HOST_RDY_OUT), 64'd0);
    chk("str_busy", 64'(BUSY_OUT), 64'd1);
  endtask

  // Present one byte until it is accepted. READY is sampled on the falling
  // edge, so the handshake happens on the following rising edge.
  task automatic sendByte(input logic [7:0] b, input logic e, input bit gaps);
    int g;
    int t;
    if (gaps) begin
      g = $urandom_range(0, 2);
      HOST_VLD_IN = 1'b0;
      repeat (g) @(negedge CLK_IN);
    end
    HOST_DAT_IN = b;
    HOST_END_IN = e;
    HOST_VLD_IN = 1'b1;
    t = 0;
    while (!HOST_RDY_OUT && t < 20) begin
      @(negedge CLK_IN);
      t++;
    end
    if (!HOST_RDY_OUT) failNow("ready_timeout");
    @(negedge CLK_IN);
    HOST_VLD_IN = 1'b0;
    HOST_END_IN = 1'b0;
  endtask

  task automatic checkOutput(input int nWr, input bit expErr);
    int t;
    t = 0;
    while (!DONE_OUT && t < 100) begin
      @(negedge CLK_IN);
      t++;
    end
    if (!DONE_OUT) failNow("done_timeout");
    repeat (2) @(negedge CLK_IN);
    chk("done", 64'(DONE_OUT), 64'd1);
    chk("busy_end", 64'(BUSY_OUT), 64'd0);
    chk("err", 64'(ERR_OUT), 64'(expErr));
    chk("wrds_final", 64'(WRDS_OUT), 64'(nWr));
    chk("rdy_end", 64'(HOST_RDY_OUT), 64'd0);
    chk("pending_words", 64'(expQ.size()), 64'd0);
  endtask

  // Reference model: split imgQ into zero-padded little-endian words. If the
  // image is longer than the ROM, the first CAP words are written and the
  // next byte is refused with an error. Otherwise all words are written (or,
  // with the checksum build, all but the last, which must equal their sum
  // and end on a word boundary). The image is then driven.
  task automatic applyStimulus(input bit doStart, input bit gaps);
    int          n;
    int          k;
    int          nWr;
    int          m;
    bit          expErr;
    logic [31:0] w[$];
    logic [31:0] word;
    exp_t        e;
`ifdef PRT_DP_PM_ROM_LDR_CKS_EN
    logic [31:0] sum;
`endif
    n = imgQ.size();
    k = (n + 3) / 4;
    w.delete();
    for (int i = 0; i < k; i++) begin
      word = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4*i + b < n) word[8*b +: 8] = imgQ[4*i + b];
      w.push_back(word);
    end
    if (n > 4*CAP) begin
      nWr    = CAP;
      expErr = 1'b1;
    end else begin
`ifdef PRT_DP_PM_ROM_LDR_CKS_EN
      nWr = k - 1;
      sum = 32'd0;
      for (int j = 0; j < nWr; j++) sum = sum + w[j];
      expErr = (n % 4 != 0) || (sum != w[k-1]);
`else
      nWr    = k;
      expErr = 1'b0;
`endif
    end
    for (int j = 0; j < nWr; j++) begin
      e.dat  = w[j];
      e.wrds = 32'(j + 1);
      expQ.push_back(e);
    end
    if (doStart) pulseStart();
    m = (n > 4*CAP) ? 4*CAP + 1 : n;
    for (int i = 0; i < m; i++) sendByte(imgQ[i], (i == n - 1), gaps);
    checkOutput(nWr, expErr);
  endtask

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;

    // Reset state
    repeat (3) @(negedge CLK_IN);
    chk("reset_outputs", {HOST_RDY_OUT, INIT_STR_OUT, INIT_VLD_OUT, BUSY_OUT, DONE_OUT,
                          ERR_OUT, WRDS_OUT, INIT_DAT_OUT}, 64'd0);
    RST_IN = 1'b0;
    @(negedge CLK_IN);
    HOST_VLD_IN = 1'b1;
    repeat (3) @(negedge CLK_IN);
    chk("idle_ignores_vld", {HOST_RDY_OUT, BUSY_OUT, DONE_OUT, INIT_VLD_OUT}, 64'd0);
    HOST_VLD_IN = 1'b0;

    // Two full words
    imgQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    applyStimulus(1'b1, 1'b0);

    // Partial, zero-padded word
    imgQ = '{8'hAA, 8'hBB, 8'hCC};
    applyStimulus(1'b1, 1'b0);

    // Overflow: 17 bytes into a four-word ROM
    imgQ.delete();
    for (int i = 0; i < 17; i++) imgQ.push_back(8'(i + 1));
    applyStimulus(1'b1, 1'b0);

    // Restart after 6 bytes; the start also collides with a valid byte
    pulseStart();
    e.dat  = 32'hA4A3A2A1;
    e.wrds = 32'd1;
    expQ.push_back(e);
    for (int i = 0; i < 6; i++) sendByte(8'hA1 + 8'(i), 1'b0, 1'b0);
    HOST_DAT_IN = 8'hEE;
    HOST_VLD_IN = 1'b1;
    pulseStart();
    HOST_VLD_IN = 1'b0;
    imgQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(1'b0, 1'b0);

    // Checksum-style images (plain data words without the checksum build)
    imgQ = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    applyStimulus(1'b1, 1'b0);
    imgQ = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
    applyStimulus(1'b1, 1'b0);

    // Random images, some long enough to overflow, with random byte gaps
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 20);
      imgQ.delete();
      for (int i = 0; i < n; i++) imgQ.push_back(8'($urandom));
      applyStimulus(1'b1, 1'b1);
    end

    // Asynchronous reset in the middle of a load
    pulseStart();
    sendByte(8'h5A, 1'b0, 1'b0);
    sendByte(8'hA5, 1'b0, 1'b0);
    RST_IN = 1'b1;
    #1;
    chk("reset_midload", {HOST_RDY_OUT, INIT_STR_OUT, INIT_VLD_OUT, BUSY_OUT, DONE_OUT,
                          ERR_OUT, WRDS_OUT, INIT_DAT_OUT}, 64'd0);
    @(negedge CLK_IN);
    RST_IN = 1'b0;
    repeat (3) @(negedge CLK_IN);
    chk("idle_after_reset", {HOST_RDY_OUT, BUSY_OUT, DONE_OUT, WRDS_OUT}, 64'd0);

    chk("str_pulse_cycles", 64'(strSeen), 64'(strExp));
    chk("leftover_words", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
